// File: rtl/alu8_result_fifo.sv
// alu8_result_fifo: registered result buffer behind the 8-bit ALU units.
// Each accepted result is stored together with its zero/negative/parity
// flags. Results are presented in order to a consumer that may stall.
// A saturating counter records the cycles in which the ALU was back-pressured.
module alu8_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_parity,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 3;

  // Each entry is laid out as {parity, neg, zero, data}.
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [7:0]    stall_q,  stall_d;

  logic          full, empty, push, pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Back-pressure depends only on occupancy. A pop in the same cycle does
  // not open a slot, so a full FIFO never passes a push through.
  assign push  = in_valid && !full;
  assign pop   = out_ready && !empty;

  // Flags are computed once here, at capture time, and are stored with the data.
  assign wr_entry = {^in_data, in_data[WIDTH-1], ~|in_data, in_data};

  // Next-state for pointers, occupancy and the saturating stall counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (in_valid && full && (stall_q != 8'hFF)) stall_d = stall_q + 8'd1;
  end

  // Control state register. Reset takes priority over a push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Entry storage. It is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = mem_q[rd_ptr_q];

  // Head presentation. It is gated to zero while the FIFO is empty, so stale
  // memory never appears on the outputs.
  always_comb begin
    out_data   = '0;
    out_zero   = 1'b0;
    out_neg    = 1'b0;
    out_parity = 1'b0;
    if (!empty) begin
      out_data   = head[WIDTH-1:0];
      out_zero   = head[WIDTH];
      out_neg    = head[WIDTH+1];
      out_parity = head[WIDTH+2];
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_alu8_result_fifo.sv
// Directed bench for alu8_result_fifo.
// A queue-based reference model is compared with the DUT on every negedge.
// Hand-computed literal expectations pin the model at key points.
module tb_alu8_result_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_neg;
  logic       out_parity;
  logic       out_ready;
  logic [2:0] count;
  logic [7:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  alu8_result_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_parity (out_parity),
    .out_ready  (out_ready),
    .count      (count),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the ordered list of stored results plus the stall count.
  logic [7:0] mq[$];
  int         mstall = 0;
  bit         armed  = 0;

  function automatic int ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) if (d[i]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mstall = 0;
      armed  = 1;
    end else begin
      bit do_pop, do_push;
      do_pop  = out_ready && (mq.size() > 0);
      do_push = in_valid && (mq.size() < DEPTH);
      if (in_valid && mq.size() == DEPTH && mstall < 255) mstall++;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(in_data);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      logic [7:0] h;
      h = (mq.size() > 0) ? mq[0] : 8'h00;
      chk("cyc_count",    int'(count),      mq.size());
      chk("cyc_in_ready", int'(in_ready),   (mq.size() < DEPTH) ? 1 : 0);
      chk("cyc_valid",    int'(out_valid),  (mq.size() > 0) ? 1 : 0);
      chk("cyc_data",     int'(out_data),   int'(h));
      chk("cyc_zero",     int'(out_zero),   (mq.size() > 0 && h == 0) ? 1 : 0);
      chk("cyc_neg",      int'(out_neg),    (mq.size() > 0 && h >= 128) ? 1 : 0);
      chk("cyc_parity",   int'(out_parity), (mq.size() > 0) ? ones(h) % 2 : 0);
      chk("cyc_stall",    int'(stall_cnt),  mstall);
    end
  end

  // Drive the inputs now (at a negedge) and advance to the next negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic head_is(input string name, input logic [7:0] d, input logic z,
                         input logic n, input logic p);
    chk({name, "_valid"},  int'(out_valid),  1);
    chk({name, "_data"},   int'(out_data),   int'(d));
    chk({name, "_zero"},   int'(out_zero),   int'(z));
    chk({name, "_neg"},    int'(out_neg),    int'(n));
    chk({name, "_parity"}, int'(out_parity), int'(p));
  endtask

  initial begin
    logic [7:0] exp_seq [5];
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_stall", int'(stall_cnt), 0);
    chk("rst_data",  int'(out_data), 0);
    rst = 1'b0;
    step(0, 8'h00, 0);
    chk("idle_count", int'(count), 0);

    // Single push and pop.
    step(1, 8'h12 ^ 8'h45, 0);
    head_is("single", 8'h57, 0, 0, 1);
    chk("single_count", int'(count), 1);
    step(0, 8'h00, 1);
    chk("single_pop_count", int'(count), 0);
    chk("single_pop_valid", int'(out_valid), 0);

    // Flag encodings.
    step(1, 8'hD5, 0);
    step(1, 8'h00, 0);
    step(1, 8'hF7, 0);
    head_is("flag_d5", 8'hD5, 0, 1, 1);
    step(0, 8'h00, 1);
    head_is("flag_00", 8'h00, 1, 0, 0);
    step(0, 8'h00, 1);
    head_is("flag_f7", 8'hF7, 0, 1, 1);
    step(0, 8'h00, 1);
    chk("flag_empty", int'(out_valid), 0);

    // Fill, then stall the producer.
    step(1, 8'h43, 0);
    step(1, 8'h57, 0);
    step(1, 8'h1F, 0);
    step(1, 8'hF7, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h57, 0);
    chk("fill_count", int'(count), 4);
    chk("fill_ready", int'(in_ready), 0);
    chk("fill_stall", int'(stall_cnt), 3);
    chk("drain0", int'(out_data), 8'h43);
    step(1, 8'h57, 1);
    chk("drain_after_pop_count", int'(count), 3);
    chk("drain_after_pop_ready", int'(in_ready), 1);
    chk("drain1", int'(out_data), 8'h57);
    step(1, 8'h57, 1);
    chk("drain_held_count", int'(count), 3);
    exp_seq[2] = 8'h1F; exp_seq[3] = 8'hF7; exp_seq[4] = 8'h57;
    for (int i = 2; i < 5; i++) begin
      chk("drain_seq", int'(out_data), int'(exp_seq[i]));
      step(0, 8'h00, 1);
    end
    chk("drain_empty", int'(out_valid), 0);
    chk("drain_stall", int'(stall_cnt), 4);

    // Simultaneous push/pop across pointer wrap.
    step(1, 8'h00, 0);
    for (int i = 1; i <= 10; i++) begin
      chk("wrap_head", int'(out_data), i - 1);
      step(1, 8'(i), 1);
      chk("wrap_count", int'(count), 1);
    end
    chk("wrap_last", int'(out_data), 8'h0A);
    step(0, 8'h00, 1);

    // Stall counter saturation, then a reset in mid-operation.
    for (int i = 0; i < 4; i++) step(1, 8'(8'hA0 + i), 0);
    for (int i = 0; i < 300; i++) step(1, 8'h77, 0);
    chk("sat_stall", int'(stall_cnt), 255);
    step(1, 8'h77, 0);
    chk("sat_hold", int'(stall_cnt), 255);
    chk("sat_head", int'(out_data), 8'hA0);
    rst = 1'b1;
    step(1, 8'h77, 1);
    rst = 1'b0;
    chk("mrst_count", int'(count), 0);
    chk("mrst_stall", int'(stall_cnt), 0);
    chk("mrst_valid", int'(out_valid), 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    chk("end_valid", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
